// File: rtl/net_tx_pkt_buffer.sv
// Store-and-forward transmit packet buffer: words become visible only once their packet is complete.
// Optional drop counter enabled by defining NET_TX_BUF_DROP_CNT_EN.
module net_tx_pkt_buffer #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_bits,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_bits,
  output logic        out_last,
  output logic [31:0] drop_count
);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [PtrW-1:0] DepthP = PtrW'(DEPTH);

  typedef enum logic {StAccept, StDrop} wr_state_e;

  wr_state_e       state_q, state_d;
  logic [64:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] fill;
  logic            beat, full, wr_en, drop_en, rd_en;

  // Never back-pressure; overflowing packets are discarded instead.
  assign in_ready = reset;
  assign beat     = in_valid && in_ready;
  assign fill     = wr_ptr_q - rd_ptr_q;
  assign full     = (fill == DepthP);

  assign out_valid = reset && (rd_ptr_q != commit_ptr_q);
  assign rd_en     = out_valid && out_ready;
  assign {out_last, out_bits} = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StAccept;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccept: if (drop_en && !in_last) state_d = StDrop;
      StDrop:   if (beat && in_last) state_d = StAccept;
      default:  state_d = StAccept;
    endcase
  end

  always_comb begin
    wr_en   = beat && (state_q == StAccept) && !full;
    drop_en = beat && (state_q == StAccept) && full;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (in_last) commit_ptr_d = wr_ptr_q + 1'b1;
    end else if (drop_en) begin
      // Rewind over the partial packet written so far.
      wr_ptr_d = commit_ptr_q;
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= {in_last, in_bits};
  end

`ifdef NET_TX_BUF_DROP_CNT_EN
  logic [31:0] drop_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (drop_en) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_net_tx_pkt_buffer.sv
// Bench for net_tx_pkt_buffer (DEPTH=8): queue-based packet model checked every cycle,
// plus directed packet scenarios with literal expectations.
module tb_net_tx_pkt_buffer;
  localparam int unsigned DEPTH = 8;
`ifdef NET_TX_BUF_DROP_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_bits = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_bits;
  logic        out_last;
  logic [31:0] drop_count;

  int tests = 0;
  int failed = 0;

  // Model state: committed words, words of the packet in progress, drop bookkeeping.
  logic [64:0] mq[$];
  logic [64:0] pq[$];
  int unsigned m_drop = 0;
  bit          m_dropping = 1'b0;

  logic [63:0] rx[$];
  bit          rxl[$];

  net_tx_pkt_buffer #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bits   (out_bits),
    .out_last   (out_last),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_drop(input int unsigned n);
    return CntEn ? n : 32'd0;
  endfunction

  always @(posedge clock) begin
    int occ;
    if (!reset) begin
      mq.delete();
      pq.delete();
      m_drop = 0;
      m_dropping = 1'b0;
    end else begin
      occ = mq.size() + pq.size();
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (in_valid) begin
        if (m_dropping) begin
          if (in_last) m_dropping = 1'b0;
        end else if (occ == DEPTH) begin
          m_drop++;
          pq.delete();
          m_dropping = !in_last;
        end else begin
          pq.push_back({in_last, in_bits});
          if (in_last) begin
            foreach (pq[i]) mq.push_back(pq[i]);
            pq.delete();
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [64:0] head;
    check("in_ready", 64'(in_ready), 64'(reset));
    check("out_valid", 64'(out_valid), 64'(reset && mq.size() != 0));
    if (reset && mq.size() != 0) begin
      head = mq[0];
      check("out_bits", out_bits, head[63:0]);
      check("out_last", 64'(out_last), 64'(head[64]));
    end
    check("drop_count", 64'(drop_count), 64'(exp_drop(m_drop)));
    if (out_valid && out_ready) begin
      rx.push_back(out_bits);
      rxl.push_back(out_last);
    end
  end

  task automatic send(input logic [63:0] d, input logic l);
    in_valid = 1'b1;
    in_bits  = d;
    in_last  = l;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_drop", 64'(drop_count), 64'd0);

    // Three-beat packet, streaming out.
    rx.delete(); rxl.delete();
    out_ready = 1'b1;
    send(64'h11, 1'b0);
    send(64'h22, 1'b0);
    check("s1_no_early_valid", 64'(out_valid), 64'd0);
    send(64'h33, 1'b1);
    check("s1_valid_after_last", 64'(out_valid), 64'd1);
    idle(4);
    check("s1_rx_count", 64'(rx.size()), 64'd3);
    if (rx.size() == 3) begin
      check("s1_w0", rx[0], 64'h11);
      check("s1_w1", rx[1], 64'h22);
      check("s1_w2", rx[2], 64'h33);
      check("s1_last_pattern", 64'({rxl[0], rxl[1], rxl[2]}), 64'b001);
    end
    check("s1_drop", 64'(drop_count), 64'd0);

    // Two 4-beat packets fill the buffer; the next packet is dropped.
    rx.delete(); rxl.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(64'h40 + 64'(i), i == 3);
    for (int i = 0; i < 4; i++) send(64'h50 + 64'(i), i == 3);
    send(64'hA0, 1'b0);
    send(64'hA1, 1'b1);
    check("s2_model_committed", 64'(mq.size()), 64'd8);
    check("s2_drop", 64'(drop_count), 64'(exp_drop(1)));
    out_ready = 1'b1;
    idle(12);
    check("s2_rx_count", 64'(rx.size()), 64'd8);
    if (rx.size() == 8) begin
      check("s2_first", rx[0], 64'h40);
      check("s2_last_word", rx[7], 64'h53);
    end

    // Oversized packet never appears; the following packet does.
    rx.delete(); rxl.delete();
    for (int i = 0; i < 10; i++) begin
      send(64'h60 + 64'(i), i == 9);
      check("s3_no_valid", 64'(out_valid), 64'd0);
    end
    check("s3_drop", 64'(drop_count), 64'(exp_drop(2)));
    send(64'hB0, 1'b0);
    send(64'hB1, 1'b1);
    idle(4);
    check("s3_rx_count", 64'(rx.size()), 64'd2);
    if (rx.size() == 2) begin
      check("s3_w0", rx[0], 64'hB0);
      check("s3_w1", rx[1], 64'hB1);
    end

    // Reset in the middle of a packet discards it silently.
    rx.delete(); rxl.delete();
    send(64'h70, 1'b0);
    send(64'h71, 1'b0);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check("s4_out_valid", 64'(out_valid), 64'd0);
    check("s4_drop", 64'(drop_count), 64'd0);
    send(64'hC0, 1'b1);
    idle(3);
    check("s4_rx_count", 64'(rx.size()), 64'd1);
    if (rx.size() == 1) check("s4_w0", rx[0], 64'hC0);

    // Seven committed words, then a write coinciding with a read.
    rx.delete(); rxl.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(64'h80 + 64'(i), i == 6);
    out_ready = 1'b1;
    send(64'hD0, 1'b1);
    idle(10);
    check("s5_rx_count", 64'(rx.size()), 64'd8);
    if (rx.size() == 8) check("s5_eighth", rx[7], 64'hD0);
    check("s5_drop", 64'(drop_count), 64'd0);

    // Full buffer: a read in the same cycle does not make room.
    rx.delete(); rxl.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(64'h90 + 64'(i), 1'b1);
    out_ready = 1'b1;
    send(64'hE0, 1'b1);
    check("s6_drop", 64'(drop_count), 64'(exp_drop(1)));
    idle(10);
    check("s6_rx_count", 64'(rx.size()), 64'd8);
    if (rx.size() == 8) check("s6_last_word", rx[7], 64'h97);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/net_tx_pkt_buffer.md
NET_TX_PKT_BUFFER -- requirements
Module: net_tx_pkt_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, buffer capacity in 64-bit words (power of 2, >= 4).
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets).
REQ-004 SHALL have port in_valid  input  1  upstream beat valid.
REQ-005 SHALL have port in_ready  output  1  upstream beat accepted when in_valid&&in_ready.
REQ-006 SHALL have port in_bits  input  64  upstream data word.
REQ-007 SHALL have port in_last  input  1  marks final beat of a packet.
REQ-008 SHALL have port out_valid  output  1  committed word available; drives the simulated NIC's net_out_valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts when out_valid&&out_ready.
REQ-010 SHALL have port out_bits  output  64  word at read pointer.
REQ-011 SHALL have port out_last  output  1  stored in_last of the word at read pointer.
REQ-012 SHALL have port drop_count  output  32  number of packets discarded.

Function
- REQ-013 Store-and-forward: SHALL never present a word on out_* until its whole packet (through in_last) is written.
- REQ-014 Storage: DEPTH entries of {last,bits}; pointers wr_ptr, commit_ptr, rd_ptr, each log2(DEPTH)+1 bits, wrap modulo 2*DEPTH.
- REQ-015 Full: (wr_ptr - rd_ptr) == DEPTH; evaluated on current-cycle registers only; a same-cycle read does not free space until next cycle.
- REQ-016 in_ready SHALL be 1 whenever reset==1; beats are never back-pressured, only dropped.
- REQ-017 Writer FSM states ACCEPT, DROP; reset state ACCEPT.
- REQ-018 ACCEPT, beat accepted, not full: write entry at wr_ptr, wr_ptr+1; if in_last, commit_ptr <= wr_ptr+1.
- REQ-019 ACCEPT, beat accepted, full: discard beat, wr_ptr <= commit_ptr, drop_count+1; if in_last stay ACCEPT, else go DROP.
- REQ-020 DROP: discard every beat; on beat with in_last go ACCEPT; no pointer or counter change.
- REQ-021 Packet longer than DEPTH words SHALL always be dropped, counted once.
- REQ-022 out_valid = (rd_ptr != commit_ptr); out_bits/out_last combinational read of entry rd_ptr; rd_ptr+1 on handshake.
- REQ-023 Latency: out_valid SHALL rise the cycle after the in_last beat is accepted (buffer previously empty).
- REQ-024 Simultaneous write and read in one cycle SHALL both take effect.
- REQ-025 drop_count SHALL wrap from 0xFFFFFFFF to 0.

Reset
- REQ-026 On reset==0 at posedge: wr_ptr, commit_ptr, rd_ptr, drop_count <= 0; FSM <= ACCEPT.
- REQ-027 During and after reset: out_valid=0, in_ready=0 while reset==0; partial packets are discarded without counting; storage contents need not be cleared.

Configuration
- REQ-028 Macro NET_TX_BUF_DROP_CNT_EN defined: drop_count SHALL behave per REQ-019/REQ-025.
- REQ-029 Macro undefined: drop_count SHALL be tied to 0 and no counter register SHALL exist; drop behaviour otherwise unchanged.

Verification (DEPTH=8, NET_TX_BUF_DROP_CNT_EN defined)
- REQ-030 Beats 0x11,0x22,0x33(last), out_ready=1 -> out_valid rises cycle after 0x33 accepted; outputs 0x11,0x22,0x33, out_last only on 0x33; drop_count=0.
- REQ-031 out_ready=0; two 4-beat packets, then 2-beat packet 0xA0,0xA1(last) -> first 8 words committed, 0xA0 packet dropped, drop_count=1; out_ready=1 drains exactly 8 words.
- REQ-032 10-beat packet -> out_valid stays 0, drop_count=1, FSM DROP until beat 10; following 2-beat packet 0xB0,0xB1 delivered intact.
- REQ-033 Reset (reset=0, 1 cycle) after 2 beats of a 3-beat packet -> out_valid=0, drop_count=0; next 1-beat packet 0xC0(last) emerges alone.
- REQ-034 Buffer holding 7 committed words, out_ready=1 while 1-beat packet 0xD0(last) written same cycle as a read -> no drop, 0xD0 emerges eighth, drop_count unchanged.
